mem_block_copier: RTL and testbench

- Bus initiator that drives the processor-side memory interface of the address decoder: address, write enable and write data.
- On command it copies a block of 32-bit words. Each word is read from a source base, then written to a destination base.
- Typical use: move ciphertext from the encrypted region (0x400..) into the decrypted region, or RAM (0x4100..), without processor involvement.
- The memory read path is synchronous with a fixed read latency.

---
 rtl/mem_block_copier.sv | 178 +++++++++++++++++
 tb/tb_mem_block_copier.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_block_copier.sv
// mem_block_copier
// ----------------
// Bus initiator that copies a block of 32-bit words from a source base to a
// destination base through the processor-side port of the address decoder.
// Each word is read (the address is held for the fixed read latency), captured,
// and then written to the destination.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle command strobe, accepted only when idle
//   abort        cancels the transfer in progress
//   src_base     source byte address (low two bits ignored)
//   dst_base     destination byte address (low two bits ignored)
//   length       number of words to copy
//   data_output  read data returned by the decoder
//   address      bus address
//   write_enable bus write strobe
//   data_input   bus write data (last captured word)
//   busy         high while a transfer is active
//   done         one-cycle pulse on completion
//   aborted      one-cycle pulse on abort
//   words_left   remaining word count

module mem_block_copier #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] data_output,
  output logic [ADDR_W-1:0] address,
  output logic              write_enable,
  output logic [DATA_W-1:0] data_input,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  words_left
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE,
    DONE,
    ABORT
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [DATA_W-1:0] capture_q;
  // Two bits cover the largest supported latency (RD_LAT-1 <= 3).
  logic [1:0]        wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Abort takes priority over normal progress in every active state; in
  // IDLE only start is looked at, so a simultaneous abort loses to start.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (length != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        state_next = abort ? ABORT : WAIT;
      end
      WAIT: begin
        if (abort) begin
          state_next = ABORT;
        end else if (wait_cnt == 2'd0) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (abort) begin
          state_next = ABORT;
        end else if (words_left == LEN_W'(1)) begin
          state_next = DONE;
        end else begin
          state_next = ISSUE;
        end
      end
      DONE:    state_next = IDLE;
      ABORT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The write in WRITE always completes, even when abort is seen in the same
  // cycle, so the pointers and count advance on every exit from WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ptr    <= '0;
      dst_ptr    <= '0;
      words_left <= '0;
      capture_q  <= '0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            words_left <= length;
            if (length != '0) begin
              src_ptr <= src_base & ~ADDR_W'(3);
              dst_ptr <= dst_base & ~ADDR_W'(3);
            end
          end
        end
        ISSUE: begin
          wait_cnt <= 2'(RD_LAT - 1);
        end
        WAIT: begin
          if (!abort) begin
            if (wait_cnt == 2'd0) begin
              capture_q <= data_output;
            end else begin
              wait_cnt <= wait_cnt - 2'd1;
            end
          end
        end
        WRITE: begin
          src_ptr    <= src_ptr + ADDR_W'(4);
          dst_ptr    <= dst_ptr + ADDR_W'(4);
          words_left <= words_left - LEN_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decode purely from the state register so an asynchronous reset
  // forces them to zero immediately.
  always_comb begin
    address      = '0;
    write_enable = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    aborted      = 1'b0;
    case (state)
      ISSUE, WAIT: begin
        address = src_ptr;
        busy    = 1'b1;
      end
      WRITE: begin
        address      = dst_ptr;
        write_enable = 1'b1;
        busy         = 1'b1;
      end
      DONE:    done    = 1'b1;
      ABORT:   aborted = 1'b1;
      default: begin
      end
    endcase
  end

  assign data_input = capture_q;

endmodule

// File: tb/tb_mem_block_copier.sv
// tb_mem_block_copier
// -------------------
// Two copier instances (read latency 1 and 3) share the command inputs; a
// select bit routes start/abort to one of them and picks whose outputs are
// observed. Each instance sees a memory that returns a known word exactly
// RD_LAT cycles after the first cycle of a read, and junk at any other time.

module tb_mem_block_copier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        sel;
  logic [31:0] src_base;
  logic [31:0] dst_base;
  logic [15:0] length;

  logic        start_a, start_b, abort_a, abort_b;
  logic [31:0] addr_a, addr_b, din_a, din_b, dout_a, dout_b;
  logic        we_a, we_b, busy_a, busy_b, done_a, done_b, abt_a, abt_b;
  logic [15:0] wl_a, wl_b;

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign abort_a = abort & ~sel;
  assign abort_b = abort & sel;

  mem_block_copier #(.RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .src_base(src_base), .dst_base(dst_base), .length(length),
    .data_output(dout_a), .address(addr_a), .write_enable(we_a),
    .data_input(din_a), .busy(busy_a), .done(done_a), .aborted(abt_a),
    .words_left(wl_a)
  );

  mem_block_copier #(.RD_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .src_base(src_base), .dst_base(dst_base), .length(length),
    .data_output(dout_b), .address(addr_b), .write_enable(we_b),
    .data_input(din_b), .busy(busy_b), .done(done_b), .aborted(abt_b),
    .words_left(wl_b)
  );

  // Memory contents: a fixed scrambling of the byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
  endfunction

  // Read-latency model: a read starts on the first cycle the bus shows a
  // busy non-write cycle after a non-read cycle.
  int          cyc = 0;
  logic [3:0]  vp_a = '0;
  logic [3:0]  vp_b = '0;
  logic        prd_a = 1'b0;
  logic        prd_b = 1'b0;
  logic [31:0] ap_a [4];
  logic [31:0] ap_b [4];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    prd_a <= busy_a & ~we_a;
    prd_b <= busy_b & ~we_b;
    vp_a  <= {vp_a[2:0], busy_a & ~we_a & ~prd_a};
    vp_b  <= {vp_b[2:0], busy_b & ~we_b & ~prd_b};
    ap_a[0] <= addr_a;
    ap_b[0] <= addr_b;
    for (int i = 1; i < 4; i++) begin
      ap_a[i] <= ap_a[i-1];
      ap_b[i] <= ap_b[i-1];
    end
  end

  assign dout_a = vp_a[0] ? mem_word(ap_a[0]) : (32'hBAD00000 ^ 32'(cyc));
  assign dout_b = vp_b[2] ? mem_word(ap_b[2]) : (32'hBAD00000 ^ 32'(cyc));

  // Outputs of the currently selected instance.
  logic [31:0] c_addr, c_din;
  logic        c_we, c_busy, c_done, c_abt;
  logic [15:0] c_wl;

  always_comb begin
    c_addr = sel ? addr_b : addr_a;
    c_din  = sel ? din_b  : din_a;
    c_we   = sel ? we_b   : we_a;
    c_busy = sel ? busy_b : busy_a;
    c_done = sel ? done_b : done_a;
    c_abt  = sel ? abt_b  : abt_a;
    c_wl   = sel ? wl_b   : wl_a;
  end

  int passed = 0;
  int total  = 0;
  int failed = 0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: expected bus traffic from the transfer rules.
  logic [31:0] exp_issue[$], exp_waddr[$], exp_wdata[$];
  logic [31:0] obs_issue[$], obs_waddr[$], obs_wdata[$];
  int          exp_wl[$], obs_wl[$];

  task automatic ref_model(input logic [31:0] src, input logic [31:0] dst,
                           input int len, input int lat, input int abort_k,
                           output int busy_cycles);
    int n;
    logic [31:0] s, d;
    exp_issue.delete();
    exp_waddr.delete();
    exp_wdata.delete();
    exp_wl.delete();
    s = src & 32'hFFFFFFFC;
    d = dst & 32'hFFFFFFFC;
    n = (abort_k >= 0) ? abort_k + 1 : len;
    for (int i = 0; i < n; i++) begin
      exp_issue.push_back(s + 32'(4 * i));
      exp_waddr.push_back(d + 32'(4 * i));
      exp_wdata.push_back(mem_word(s + 32'(4 * i)));
      exp_wl.push_back(len - i);
    end
    busy_cycles = n * (lat + 2);
  endtask

  typedef struct {
    bit          sel;
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          abort_k;
    bit          inject;
    bit          abort_start;
    int          exp_end;
    int          exp_wl;
  } vec_t;

  task automatic applyStimulus(input vec_t v, input string tag);
    int exp_busy, k, nw, busy_cnt, consec, done_k, abt_k, end_wl;
    bit fin, prev_we, prev_rd;
    ref_model(v.src, v.dst, v.len, v.sel ? 3 : 1, v.abort_k, exp_busy);
    obs_issue.delete();
    obs_waddr.delete();
    obs_wdata.delete();
    obs_wl.delete();
    k = 0; nw = 0; busy_cnt = 0; consec = 0; done_k = 0; abt_k = 0;
    end_wl = -1; fin = 0; prev_we = 0; prev_rd = 0;

    @(negedge clk);
    sel      = v.sel;
    src_base = v.src;
    dst_base = v.dst;
    length   = 16'(v.len);
    start    = 1'b1;
    abort    = v.abort_start;

    while (!fin && k < exp_busy + 20) begin
      @(negedge clk);
      k++;
      abort = 1'b0;
      if (k == 1) start = 1'b0;
      if (v.inject && k == 2) begin
        start    = 1'b1;
        src_base = 32'h12345678;
        dst_base = 32'h0BADF00C;
        length   = 16'd9;
      end
      if (v.inject && k == 3) start = 1'b0;
      if (c_busy) busy_cnt++;
      if (c_busy && !c_we && !prev_rd) obs_issue.push_back(c_addr);
      if (c_we) begin
        if (prev_we) consec++;
        obs_waddr.push_back(c_addr);
        obs_wdata.push_back(c_din);
        obs_wl.push_back(int'(c_wl));
        if (nw == v.abort_k) abort = 1'b1;
        nw++;
      end
      if (c_done) begin done_k = k; fin = 1; end_wl = int'(c_wl); end
      if (c_abt)  begin abt_k = k;  fin = 1; end_wl = int'(c_wl); end
      prev_we = c_we;
      prev_rd = c_busy & ~c_we;
    end
    start = 1'b0;
    abort = 1'b0;

    checkOutput({tag, " finished"}, 32'(fin), 32'd1);
    if (v.abort_k >= 0) begin
      checkOutput({tag, " aborted_cycle"}, 32'(abt_k), 32'(v.exp_end));
      checkOutput({tag, " no_done"}, 32'(done_k), 32'd0);
    end else begin
      checkOutput({tag, " done_cycle"}, 32'(done_k), 32'(v.exp_end));
      checkOutput({tag, " no_aborted"}, 32'(abt_k), 32'd0);
    end
    checkOutput({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    checkOutput({tag, " we_back_to_back"}, 32'(consec), 32'd0);
    checkOutput({tag, " words_left_end"}, 32'(end_wl), 32'(v.exp_wl));
    checkOutput({tag, " issue_count"}, 32'(obs_issue.size()), 32'(exp_issue.size()));
    checkOutput({tag, " write_count"}, 32'(obs_waddr.size()), 32'(exp_waddr.size()));
    for (int i = 0; i < obs_issue.size() && i < exp_issue.size(); i++)
      checkOutput($sformatf("%s rd_addr[%0d]", tag, i), obs_issue[i], exp_issue[i]);
    for (int i = 0; i < obs_waddr.size() && i < exp_waddr.size(); i++) begin
      checkOutput($sformatf("%s wr_addr[%0d]", tag, i), obs_waddr[i], exp_waddr[i]);
      checkOutput($sformatf("%s wr_data[%0d]", tag, i), obs_wdata[i], exp_wdata[i]);
      checkOutput($sformatf("%s wr_left[%0d]", tag, i), 32'(obs_wl[i]), 32'(exp_wl[i]));
    end

    // Back in IDLE: nothing active, count and last captured word hold.
    @(negedge clk);
    checkOutput({tag, " idle_busy"}, 32'(c_busy), 32'd0);
    checkOutput({tag, " idle_pulses"}, 32'({c_done, c_abt}), 32'd0);
    checkOutput({tag, " idle_words_left"}, 32'(c_wl), 32'(v.exp_wl));
    if (exp_wdata.size() > 0)
      checkOutput({tag, " idle_data_input"}, c_din, exp_wdata[exp_wdata.size()-1]);
  endtask

  vec_t tbl[8];

  initial begin
    int pulses, busy_seen, lat, n;
    vec_t r;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel = 1'b0;
    src_base = '0; dst_base = '0; length = '0;

    tbl[0] = '{0, 32'h00000400, 32'h00004100, 4, -1, 0, 0, 13, 0};
    tbl[1] = '{0, 32'h00000400, 32'h00004100, 0, -1, 0, 0, 1, 0};
    tbl[2] = '{0, 32'hFFFFFFF8, 32'h00030000, 3, -1, 0, 0, 10, 0};
    tbl[3] = '{0, 32'h00000400, 32'h00004100, 4, 1, 1, 0, 7, 2};
    tbl[4] = '{1, 32'h00001000, 32'h00002000, 2, -1, 0, 0, 11, 0};
    tbl[5] = '{1, 32'h00000403, 32'h00004102, 2, -1, 0, 0, 11, 0};
    tbl[6] = '{1, 32'h00000010, 32'h00000020, 3, 0, 0, 0, 6, 2};
    tbl[7] = '{0, 32'h00000800, 32'h00000900, 2, -1, 0, 1, 7, 0};

    // Reset held with the clock running.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst addr_a", addr_a, 32'd0);
    checkOutput("rst we_a", 32'(we_a), 32'd0);
    checkOutput("rst din_a", din_a, 32'd0);
    checkOutput("rst busy_a", 32'(busy_a), 32'd0);
    checkOutput("rst done_a", 32'(done_a), 32'd0);
    checkOutput("rst aborted_a", 32'(abt_a), 32'd0);
    checkOutput("rst words_left_a", 32'(wl_a), 32'd0);
    checkOutput("rst addr_b", addr_b, 32'd0);
    checkOutput("rst busy_b", 32'(busy_b), 32'd0);
    checkOutput("rst din_b", din_b, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst busy_a", 32'(busy_a), 32'd0);
    checkOutput("post_rst busy_b", 32'(busy_b), 32'd0);

    for (int i = 0; i < 8; i++) applyStimulus(tbl[i], $sformatf("vec%0d", i));

    // Abort while idle is ignored.
    @(negedge clk);
    sel = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("idle_abort aborted", 32'(c_abt), 32'd0);
    checkOutput("idle_abort busy", 32'(c_busy), 32'd0);

    // Randomized transfers against the reference model.
    for (int t = 0; t < 20; t++) begin
      r.sel         = 1'($urandom_range(0, 1));
      r.src         = $urandom;
      r.dst         = $urandom;
      r.len         = int'($urandom_range(1, 5));
      r.abort_k     = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, r.len - 1)) : -1;
      r.inject      = 1'($urandom_range(0, 1));
      r.abort_start = 1'b0;
      lat           = r.sel ? 3 : 1;
      n             = (r.abort_k >= 0) ? r.abort_k + 1 : r.len;
      r.exp_end     = n * (lat + 2) + 1;
      r.exp_wl      = (r.abort_k >= 0) ? r.len - n : 0;
      applyStimulus(r, $sformatf("rnd%0d", t));
    end

    // Asynchronous reset in the middle of a latency-3 read.
    @(negedge clk);
    sel = 1'b1; src_base = 32'h100; dst_base = 32'h200; length = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("midrst busy_before", 32'(busy_b), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst addr", addr_b, 32'd0);
    checkOutput("midrst we", 32'(we_b), 32'd0);
    checkOutput("midrst din", din_b, 32'd0);
    checkOutput("midrst busy", 32'(busy_b), 32'd0);
    checkOutput("midrst done", 32'(done_b), 32'd0);
    checkOutput("midrst aborted", 32'(abt_b), 32'd0);
    checkOutput("midrst words_left", 32'(wl_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    busy_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_b || abt_b) pulses++;
      if (busy_b) busy_seen++;
    end
    checkOutput("midrst no_pulses", 32'(pulses), 32'd0);
    checkOutput("midrst stays_idle", 32'(busy_seen), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
